// File: rtl/conv_pkg.sv
// conv_pkg - shared types and default sizes for the convolution x-stream path.
//   state_e      : x_stream_master FSM states (load / ready / stream / done)
//   DefDataWidth : default width of one x element
//   DefXSize     : default words per x vector
//   DefFSize     : default beats accepted before conv_start fires
package conv_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefXSize     = 128;
    localparam int unsigned DefFSize     = 32;

    typedef enum logic [1:0] {
        StLoad,
        StReady,
        StStream,
        StDone
    } state_e;

endpackage

// File: rtl/xbuf_ram.sv
// xbuf_ram - DEPTH x DATA_WIDTH vector buffer, one write port, one synchronous read port.
// Ports:
//   clk      : rising-edge clock
//   we_i     : write enable, waddr_i / wdata_i : write address / data
//   re_i     : read enable, raddr_i : read address
//   rdata_o  : read data, valid the cycle after re_i (holds otherwise)
// Contents are never cleared.
module xbuf_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/x_stream_master.sv
// x_stream_master - buffers one X_SIZE-word x vector and streams it out valid/ready.
// Ports:
//   clk, reset               : rising-edge clock, synchronous active-high reset
//   load_valid/load_data/load_ready : vector load port (accepted only in the load state)
//   start                    : stream request, honoured only when a full vector is buffered
//   busy                     : streaming in progress
//   m_valid/m_data/m_last/m_ready : output stream into the convolution unit
//   conv_start               : one-cycle pulse after the F_SIZE-th accepted beat
//   done                     : one-cycle pulse after the last accepted beat
// Build option: define X_STREAM_REPLAY_EN to keep the buffer valid after done so a new
// start replays the same vector; otherwise a full reload is required.
module x_stream_master
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned X_SIZE     = DefXSize,
    parameter int unsigned F_SIZE     = DefFSize,
    parameter int unsigned ADDR_WIDTH = $clog2(X_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    input  logic                  start,
    output logic                  busy,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  conv_start,
    output logic                  done
);

    localparam int unsigned PtrW = ADDR_WIDTH + 1;
    typedef logic [PtrW-1:0] ptr_t;
    localparam ptr_t XLast = ptr_t'(X_SIZE - 1);
    localparam ptr_t XEnd  = ptr_t'(X_SIZE);
    localparam ptr_t FLast = ptr_t'(F_SIZE - 1);

    state_e state_q, state_d;
    ptr_t   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, beat_cnt_q, beat_cnt_d;
    logic   load_ready_q, load_ready_d, busy_q, busy_d;
    logic   conv_start_q, conv_start_d, done_q, done_d;
    logic   rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;

    // Two-entry prefetch FIFO holding {data, last}.
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic [1:0]            fifo_last_q, fifo_last_d;
    logic                  fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

    logic                  load_fire, hs, rd_en;
    logic [2:0]            occ_after_pop;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign load_fire = load_valid && load_ready_q;
    assign hs        = (fifo_cnt_q != 2'd0) && m_ready;

    // Count the slot freed by this cycle's pop so a steady ready stream has no bubbles;
    // occupancy plus in-flight reads still never exceeds two.
    assign occ_after_pop = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, hs};

    // The first read is launched in the same cycle start is accepted, giving a
    // two-cycle start-to-m_valid latency.
    assign rd_en = ((state_q == StReady && start) || state_q == StStream)
                   && (rd_ptr_q < XEnd) && (occ_after_pop < 3'd2);

    xbuf_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (X_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_xbuf_ram (
        .clk     (clk),
        .we_i    (load_fire),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (load_data),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        conv_start_d = 1'b0;
        done_d       = 1'b0;
        rd_pend_d    = rd_en;
        rd_last_d    = rd_last_q;
        fifo_data_d  = fifo_data_q;
        fifo_last_d  = fifo_last_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_rd_d    = fifo_rd_q;

        unique case (state_q)
            StLoad: begin
                if (load_fire) begin
                    if (wr_ptr_q == XLast) begin
                        wr_ptr_d = '0;
                        state_d  = StReady;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ptr_t'(1);
                    end
                end
            end
            StReady: begin
                if (start) begin
                    state_d    = StStream;
                    beat_cnt_d = '0;
                end
            end
            StStream: begin
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + ptr_t'(1);
                    if (beat_cnt_q == FLast) begin
                        conv_start_d = 1'b1;
                    end
                    if (fifo_last_q[fifo_rd_q]) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                rd_ptr_d = '0;
`ifdef X_STREAM_REPLAY_EN
                state_d  = StReady;
`else
                state_d  = StLoad;
`endif
            end
            default: state_d = StLoad;
        endcase

        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + ptr_t'(1);
            rd_last_d = (rd_ptr_q == XLast);
        end

        // RAM data lands one cycle after the read was issued.
        if (rd_pend_q) begin
            fifo_data_d[fifo_wr_q] = ram_rdata;
            fifo_last_d[fifo_wr_q] = rd_last_q;
            fifo_wr_d              = ~fifo_wr_q;
        end
        if (hs) begin
            fifo_rd_d = ~fifo_rd_q;
        end
        fifo_cnt_d = fifo_cnt_q + {1'b0, rd_pend_q} - {1'b0, hs};

        load_ready_d = (state_d == StLoad);
        busy_d       = (state_d == StStream);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StLoad;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            beat_cnt_q     <= '0;
            load_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
            conv_start_q   <= 1'b0;
            done_q         <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_last_q      <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            fifo_wr_q      <= 1'b0;
            fifo_rd_q      <= 1'b0;
            fifo_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            beat_cnt_q     <= beat_cnt_d;
            load_ready_q   <= load_ready_d;
            busy_q         <= busy_d;
            conv_start_q   <= conv_start_d;
            done_q         <= done_d;
            rd_pend_q      <= rd_pend_d;
            rd_last_q      <= rd_last_d;
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            fifo_last_q    <= fifo_last_d;
            fifo_wr_q      <= fifo_wr_d;
            fifo_rd_q      <= fifo_rd_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign conv_start = conv_start_q;
    assign done       = done_q;
    assign m_valid    = (fifo_cnt_q != 2'd0);
    assign m_data     = fifo_data_q[fifo_rd_q];
    assign m_last     = fifo_last_q[fifo_rd_q];

endmodule

// File: tb/tb_x_stream_master.sv
// tb_x_stream_master - directed sequence with randomized data/backpressure for x_stream_master.
// The reference is simply the loaded vector in an array plus a count of accepted beats.
module tb_x_stream_master;

    localparam int DW = 16;
    localparam int X  = 128;
    localparam int F  = 32;
    localparam int STREAM_LIMIT = 2000;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          start;
    logic          busy;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          m_last;
    logic          conv_start;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] vec [X];

    x_stream_master dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .conv_start (conv_start),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load_valid = 1'b0;
        start = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_load_ready", load_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_conv_start", conv_start, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_load_ready", load_ready, 1);
    endtask

    task automatic fill_vec(input bit random_data);
        for (int k = 0; k < X; k++) begin
            vec[k] = random_data ? DW'($urandom) : DW'(k);
        end
    endtask

    // Loads vec with random bubbles; start is held at the given word count to prove it is ignored.
    task automatic load_vec(input int start_at);
        int i = 0;
        while (i < X) begin
            chk("load_ready_in_load", load_ready, 1);
            chk("busy_in_load", busy, 0);
            start = (i == start_at);
            if ($urandom_range(0, 3) != 0) begin
                load_valid = 1'b1;
                load_data = vec[i];
                i++;
            end else begin
                load_valid = 1'b0;
                load_data = DW'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("load_ready_after_full", load_ready, 0);
        // Junk writes while not ready must not touch the buffer.
        for (int j = 0; j < 3; j++) begin
            load_valid = 1'b1;
            load_data = DW'($urandom);
            @(negedge clk);
            chk("load_ready_ready_state", load_ready, 0);
            chk("busy_ready_state", busy, 0);
        end
        load_valid = 1'b0;
    endtask

    // mode 0: ready high, 1: toggling, 2: 50-cycle stall at first valid, 3: random.
    task automatic run_stream(input int mode, input int abort_at);
        int  idx = 0;
        int  cyc = 0;
        int  hold = 0;
        bit  exp_cs = 0;
        bit  exp_dn = 0;
        bit  prev_stall = 0;
        bit  fin = 0;
        bit  hs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("lat1_m_valid", m_valid, 0);
        chk("lat1_busy", busy, 1);
        @(negedge clk);
        chk("lat2_m_valid", m_valid, 1);
        while (cyc < STREAM_LIMIT) begin
            chk("conv_start", conv_start, exp_cs);
            chk("done", done, exp_dn);
            if (exp_dn) begin
                chk("end_busy", busy, 0);
                chk("end_m_valid", m_valid, 0);
                fin = 1;
                break;
            end
            if (prev_stall || mode == 0) chk("m_valid_held", m_valid, 1);
            if (m_valid) begin
                chk("m_data", m_data, vec[idx]);
                chk("m_last", m_last, (idx == X - 1));
            end
            if (abort_at >= 0 && idx == abort_at) begin
                reset = 1'b1;
                m_ready = 1'b0;
                @(negedge clk);
                chk("abort_m_valid", m_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_m_data", m_data, 0);
                chk("abort_load_ready", load_ready, 0);
                reset = 1'b0;
                @(negedge clk);
                chk("abort_load_ready_after", load_ready, 1);
                fin = 1;
                break;
            end
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (cyc % 2 == 0);
                2: m_ready = (hold >= 50);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (m_valid) hold++;
            hs = m_valid && m_ready;
            exp_cs = hs && (idx + 1 == F);
            exp_dn = hs && (idx == X - 1);
            prev_stall = m_valid && !m_ready;
            if (hs) idx++;
            cyc++;
            @(negedge clk);
        end
        m_ready = 1'b0;
        checks++;
        assert (fin) else begin
            errors++;
            $error("FAIL stream_timeout: observed %0d beats expected %0d", idx, X);
        end
    endtask

    task automatic check_start_ignored();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("ignored_busy", busy, 0);
            chk("ignored_m_valid", m_valid, 0);
            chk("ignored_load_ready", load_ready, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        load_valid = 1'b0;
        load_data = '0;
        start = 1'b0;
        m_ready = 1'b0;

        // Counting vector, start held during load, full-rate stream.
        do_reset();
        fill_vec(0);
        load_vec(60);
        run_stream(0, -1);
        @(negedge clk);
`ifdef X_STREAM_REPLAY_EN
        chk("replay_load_ready", load_ready, 0);
        run_stream(0, -1);
`else
        chk("noreplay_load_ready", load_ready, 1);
        check_start_ignored();
`endif

        // Toggling backpressure.
        do_reset();
        load_vec(-1);
        run_stream(1, -1);

        // Long stall on the first word.
        do_reset();
        load_vec(-1);
        run_stream(2, -1);

        // Random data with random backpressure.
        do_reset();
        fill_vec(1);
        load_vec(-1);
        run_stream(3, -1);

        // Reset after 70 beats, then start without reload must be ignored.
        do_reset();
        fill_vec(0);
        load_vec(-1);
        run_stream(0, 70);
        check_start_ignored();
        fill_vec(1);
        load_vec(-1);
        run_stream(3, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
